// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int AW_DEF          = 32;
    localparam int DW_DEF          = 32;
    localparam int MAX_DSTREAK_DEF = 4;
    localparam int TIMEOUT_DEF     = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_own_e;

    // Width of a counter that must hold 0..maxv inclusive.
    function automatic int cnt_w(input int maxv);
        return (maxv < 2) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter bundled as one interface.
interface mem_port_arbiter_if #(
    parameter int AW = mem_arb_pkg::AW_DEF,
    parameter int DW = mem_arb_pkg::DW_DEF
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_rdata;
    logic              i_ack;

    logic              d_req;
    logic [AW-1:0]     d_addr;
    logic [DW/8-1:0]   d_we;
    logic [DW-1:0]     d_wdata;
    logic [DW-1:0]     d_rdata;
    logic              d_ack;

    logic              m_req;
    logic [AW-1:0]     m_addr;
    logic [DW/8-1:0]   m_we;
    logic [DW-1:0]     m_wdata;
    logic              m_ready;
    logic [DW-1:0]     m_rdata;

    logic              bus_err;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, m_ready, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_addr, m_we, m_wdata, bus_err
    );

    // CPU + memory side.
    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, m_ready, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_addr, m_we, m_wdata, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant decision: data first, but fetch wins once data has
// taken MAX_DSTREAK consecutive grants while fetch was waiting.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
    parameter int SW          = cnt_w(MAX_DSTREAK)
) (
    input  logic          i_ireq,
    input  logic          i_dreq,
    input  logic [SW-1:0] i_streak,
    output logic          o_gnt,
    output arb_own_e      o_own,
    output logic [SW-1:0] o_streak_nxt
);

    localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

    always_comb begin
        o_gnt        = 1'b0;
        o_own        = OWN_I;
        o_streak_nxt = i_streak;
        if (i_dreq && ((i_streak < SMAX) || !i_ireq)) begin
            o_gnt = 1'b1;
            o_own = OWN_D;
            if (!i_ireq)
                o_streak_nxt = '0;
            else if (i_streak >= SMAX)
                o_streak_nxt = SMAX;
            else
                o_streak_nxt = i_streak + SW'(1);
        end else if (i_ireq) begin
            o_gnt        = 1'b1;
            o_own        = OWN_I;
            o_streak_nxt = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one single-port memory with a
// one-cycle ack per access and a watchdog that aborts stuck transactions.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int BW = DW / 8;
    localparam int SW = cnt_w(MAX_DSTREAK);
    localparam int TW = cnt_w(TIMEOUT);

    localparam logic [AW-1:0] AMASK = ~AW'(BW - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_e      r_state;
    arb_own_e        r_own;
    logic [SW-1:0]   r_streak;
    logic [TW-1:0]   r_timer;

    logic            r_m_req;
    logic [AW-1:0]   r_m_addr;
    logic [BW-1:0]   r_m_we;
    logic [DW-1:0]   r_m_wdata;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_i_ack;
    logic            r_d_ack;
    logic            r_bus_err;

    logic            w_gnt;
    arb_own_e        w_own;
    logic [SW-1:0]   w_streak_nxt;
    logic            w_done;

    arb_pick #(
        .MAX_DSTREAK (MAX_DSTREAK),
        .SW          (SW)
    ) u_pick (
        .i_ireq       (bus.i_req),
        .i_dreq       (bus.d_req),
        .i_streak     (r_streak),
        .o_gnt        (w_gnt),
        .o_own        (w_own),
        .o_streak_nxt (w_streak_nxt)
    );

    // A BUSY cycle ends on completion or on the last tolerated wait cycle.
    assign w_done = bus.m_ready || (r_timer == TLAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_own     <= OWN_I;
            r_streak  <= '0;
            r_timer   <= '0;
            r_m_req   <= 1'b0;
            r_m_addr  <= '0;
            r_m_we    <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_state  <= BUSY;
                        r_own    <= w_own;
                        r_streak <= w_streak_nxt;
                        r_m_req  <= 1'b1;
                        if (w_own == OWN_D) begin
                            r_m_addr  <= bus.d_addr & AMASK;
                            r_m_we    <= bus.d_we;
                            r_m_wdata <= bus.d_wdata;
                        end else begin
                            r_m_addr  <= bus.i_addr & AMASK;
                            r_m_we    <= '0;
                            r_m_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_state   <= RESP;
                        r_m_req   <= 1'b0;
                        r_timer   <= '0;
                        r_bus_err <= !bus.m_ready;
                        // An aborted access returns zero data to its owner.
                        if (r_own == OWN_D) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= bus.m_ready ? bus.m_rdata : '0;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= bus.m_ready ? bus.m_rdata : '0;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RESP: begin
                    // Requesters update their lines on this edge, so they are not sampled here.
                    r_state   <= IDLE;
                    r_i_ack   <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_bus_err <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_we    = r_m_we;
    assign bus.m_wdata = r_m_wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_ack   = r_i_ack;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_ack   = r_d_ack;
    assign bus.bus_err = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester drivers, a wait-state memory model and
// per-requester scoreboards of expected ack data / error.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;
    localparam int TMO  = 8;
    localparam logic [AW-1:0] MASK = 32'hFFFF_FFFC;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] we;
        logic [DW-1:0] wdata;
        logic          err;
    } rq_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_DSTREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rq_t  iq[$], dq[$];
    exp_t exp_i[$], exp_d[$];
    rq_t  cur_i, cur_d;
    logic glog[$];
    int   lens[$];
    int   iack_cyc[$], ireq_cyc[$];
    int   dack_n = 0;
    int   i_wait = 0, d_wait = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        if (a == 32'h0000_0104) return 32'h0050_0093;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic rq_t mk(input logic [AW-1:0] a, input logic [BW-1:0] we,
                               input logic [DW-1:0] wd, input logic err);
        rq_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.err = err;
        return r;
    endfunction

    // Fetch requester: holds i_req until i_ack, reloads on the ack cycle.
    initial begin
        int age = 0;
        exp_t e;
        bus.i_req = 1'b0; bus.i_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (bus.i_req && bus.i_ack) bus.i_req = 1'b0;
            if (bus.i_req) begin
                age++;
                if (age > 400) begin chk("i_stuck", 1, 0); bus.i_req = 1'b0; end
            end
            if (!bus.i_req && iq.size() > 0) begin
                cur_i = iq.pop_front();
                bus.i_addr = cur_i.addr; bus.i_req = 1'b1; age = 0;
                ireq_cyc.push_back(cyc);
                e.err  = cur_i.err;
                e.data = cur_i.err ? '0 : rd_fn(cur_i.addr & MASK);
                exp_i.push_back(e);
            end
        end
    end

    // Data requester.
    initial begin
        int age = 0;
        exp_t e;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_we = '0; bus.d_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (bus.d_req && bus.d_ack) bus.d_req = 1'b0;
            if (bus.d_req) begin
                age++;
                if (age > 400) begin chk("d_stuck", 1, 0); bus.d_req = 1'b0; end
            end
            if (!bus.d_req && dq.size() > 0) begin
                cur_d = dq.pop_front();
                bus.d_addr = cur_d.addr; bus.d_we = cur_d.we; bus.d_wdata = cur_d.wdata;
                bus.d_req = 1'b1; age = 0;
                e.err  = cur_d.err;
                e.data = cur_d.err ? '0 : rd_fn(cur_d.addr & MASK);
                exp_d.push_back(e);
            end
        end
    end

    // Memory: fetch lives below 0x2000, data above, so the owner is visible
    // from the address. Drives noise on m_ready/m_rdata whenever m_req is low.
    initial begin
        logic          in_acc = 1'b0, own_d = 1'b0;
        int            alen = 0;
        logic [AW-1:0] ca = '0;
        logic [BW-1:0] cwe = '0;
        logic [DW-1:0] cwd = '0;
        bus.m_ready = 1'b0; bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.m_req && !reset) begin
                if (!in_acc) begin
                    in_acc = 1'b1; alen = 0;
                    ca = bus.m_addr; cwe = bus.m_we; cwd = bus.m_wdata;
                    own_d = ca[13];
                    glog.push_back(own_d);
                    if (own_d) begin
                        chk("m_addr_d", ca, cur_d.addr & MASK);
                        chk("m_we_d", cwe, cur_d.we);
                        if (cur_d.we != '0) chk("m_wdata_d", cwd, cur_d.wdata);
                    end else begin
                        chk("m_addr_i", ca, cur_i.addr & MASK);
                        chk("m_we_i", cwe, 0);
                    end
                end else begin
                    chk("stab_addr", bus.m_addr, ca);
                    chk("stab_we", bus.m_we, cwe);
                    chk("stab_wdata", bus.m_wdata, cwd);
                end
                alen++;
                if (alen > (own_d ? d_wait : i_wait)) begin
                    bus.m_ready = 1'b1; bus.m_rdata = rd_fn(ca);
                end else begin
                    bus.m_ready = 1'b0; bus.m_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                if (in_acc) begin lens.push_back(alen); in_acc = 1'b0; end
                bus.m_ready = 1'b1;
                bus.m_rdata = 32'hBAD0_0000 | DW'(cyc);
            end
        end
    end

    // Ack monitor / scoreboard pop.
    initial begin
        logic prev_i = 1'b0, prev_d = 1'b0;
        logic [DW-1:0] last_i = '0, last_d = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_i = 1'b0; prev_d = 1'b0; last_i = '0; last_d = '0;
                continue;
            end
            if (bus.i_ack) begin
                chk("i_pulse", prev_i, 0);
                chk("one_ack", bus.d_ack, 0);
                iack_cyc.push_back(cyc);
                if (exp_i.size() == 0) chk("i_unexp", 1, 0);
                else begin
                    e = exp_i.pop_front();
                    chk("i_rdata", bus.i_rdata, e.data);
                    chk("i_err", bus.bus_err, e.err);
                end
                last_i = bus.i_rdata;
            end else chk("i_hold", bus.i_rdata, last_i);
            if (bus.d_ack) begin
                chk("d_pulse", prev_d, 0);
                dack_n++;
                if (exp_d.size() == 0) chk("d_unexp", 1, 0);
                else begin
                    e = exp_d.pop_front();
                    chk("d_rdata", bus.d_rdata, e.data);
                    chk("d_err", bus.bus_err, e.err);
                end
                last_d = bus.d_rdata;
            end else chk("d_hold", bus.d_rdata, last_d);
            if (bus.bus_err && !bus.i_ack && !bus.d_ack) chk("err_alone", 1, 0);
            prev_i = bus.i_ack; prev_d = bus.d_ack;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || bus.i_req || bus.d_req ||
                exp_i.size() != 0 || exp_d.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_tmo", n >= 300, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic exp_ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int d0, n;

        repeat (3) @(negedge clk);
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_acks", {bus.i_ack, bus.d_ack, bus.bus_err}, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back fetches.
        repeat (3) iq.push_back(mk(32'h0000_0104, '0, '0, 1'b0));
        wait_idle();
        chk("fetch_n", iack_cyc.size(), 3);
        if (iack_cyc.size() == 3 && ireq_cyc.size() >= 1) begin
            chk("fetch_lat", iack_cyc[0] - ireq_cyc[0], 2);
            chk("fetch_per1", iack_cyc[1] - iack_cyc[0], 3);
            chk("fetch_per2", iack_cyc[2] - iack_cyc[1], 3);
        end

        // Misaligned byte store.
        d0 = dack_n;
        dq.push_back(mk(32'h0000_2003, 4'b1000, 32'hAB00_0000, 1'b0));
        wait_idle();
        chk("store_acks", dack_n - d0, 1);

        // Contention with both requesters held high.
        glog.delete();
        for (int k = 0; k < 8; k++)
            dq.push_back(mk(32'h0000_2010 + 32'(16 * k), (k % 2) ? 4'hF : 4'h0,
                            32'h1000_0000 + 32'(k), 1'b0));
        iq.push_back(mk(32'h0000_0200, '0, '0, 1'b0));
        iq.push_back(mk(32'h0000_0206, '0, '0, 1'b0));
        wait_idle();
        chk("ord_n", glog.size(), 10);
        for (int k = 0; k < 10 && k < glog.size(); k++) chk("ord", glog[k], exp_ord[k]);

        // Five wait states.
        lens.delete();
        d_wait = 5;
        dq.push_back(mk(32'h0000_2100, '0, '0, 1'b0));
        wait_idle();
        d_wait = 0;
        chk("wait_len_n", lens.size(), 1);
        if (lens.size() == 1) chk("wait_len", lens[0], 6);

        // Watchdog abort followed by a waiting fetch.
        lens.delete(); glog.delete();
        d_wait = 255;
        dq.push_back(mk(32'h0000_2200, '0, '0, 1'b1));
        iq.push_back(mk(32'h0000_0300, '0, '0, 1'b0));
        wait_idle();
        d_wait = 0;
        chk("tmo_len_n", lens.size(), 2);
        if (lens.size() >= 1) chk("tmo_len", lens[0], TMO);
        chk("tmo_ord_n", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("tmo_ord0", glog[0], 1);
            chk("tmo_ord1", glog[1], 0);
        end

        // Reset during the second BUSY cycle of a stuck data access.
        glog.delete();
        d_wait = 255;
        dq.push_back(mk(32'h0000_2400, '0, '0, 1'b0));
        iq.push_back(mk(32'h0000_0400, '0, '0, 1'b0));
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.m_req && n < 20);
        chk("rst_wait_busy", bus.m_req, 1);
        @(posedge clk); #1;
        chk("streak_pre", dut.r_streak, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_m_req", bus.m_req, 0);
        chk("rst_mid_acks", {bus.i_ack, bus.d_ack}, 0);
        @(negedge clk);
        d_wait = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_state", dut.r_state, 0);
        chk("rst_streak", dut.r_streak, 0);
        wait_idle();
        chk("rst_ord_n", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("rst_ord0", glog[0], 1);
            chk("rst_ord1", glog[1], 1);
            chk("rst_ord2", glog[2], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipelined CPU's instruction-fetch requester (I) and its MEM-stage data requester (D).
- Serialises accesses and returns a one-cycle acknowledge to the winning requester. The CPU stalls the corresponding stage while that stage's request is high and its ack is low.
- Data has priority, with bounded starvation of fetch. A watchdog aborts memory transactions that never complete.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables = DW/8)
- MAX_DSTREAK, 4, maximum consecutive D grants while I is waiting
- TIMEOUT, 255, memory-wait cycles before abort

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data, valid when i_ack
- i_ack  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request, level, held until d_ack
- d_addr  in  AW  data address
- d_we  in  DW/8  byte write enables; 0 means read
- d_wdata  in  DW  store data, already lane-aligned
- d_rdata  out  DW  load data, valid when d_ack
- d_ack  out  1  data complete, one-cycle pulse
- m_req  out  1  memory request
- m_addr  out  AW  word-aligned memory address
- m_we  out  DW/8  memory byte enables
- m_wdata  out  DW  memory write data
- m_ready  in  1  memory completes the current access this cycle
- m_rdata  in  DW  memory read data, valid with m_ready
- bus_err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Interface decision: reset reset, asynchronous, active-high; clock clk.
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, streak counter 0, timer 0.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If d_req and (streak < MAX_DSTREAK or !i_req): grant D.
  - Else if i_req: grant I.
  - On a grant, latch the requester, address (low log2(DW/8) bits forced to 0), we and wdata, then go to BUSY.
  - The fetch path always drives m_we = 0.
- BUSY:
  - m_req = 1, with m_addr, m_we and m_wdata from the latched values, held stable.
  - On m_ready:
    - capture m_rdata into the granted requester's rdata register;
    - pulse that requester's ack in the next cycle;
    - clear m_req in the next cycle;
    - go to RESP.
- RESP:
  - Exactly one ack is high.
  - Request lines are NOT sampled in this cycle, because the requester drops or changes its request at this edge.
  - Go to IDLE.
- Minimum latency: request seen in IDLE at edge n, m_req high in cycle n+1, ack high in cycle n+2 when m_ready is high in n+1. Throughput is at most 1 access per 3 cycles.
- Streak counter:
  - Increments on each D grant while i_req is high, saturating at MAX_DSTREAK.
  - Clears on any I grant, or on a D grant while i_req is low.
  - When i_req and d_req are both high with streak = MAX_DSTREAK, I wins.
- Timer:
  - Counts BUSY cycles without m_ready.
  - When the count reaches TIMEOUT:
    - drop m_req;
    - pulse bus_err and the granted ack together in the next cycle, with rdata = 0;
    - go to RESP.
  - The timer clears on leaving BUSY.
- Requests that arrive during BUSY or RESP wait. Address changes while a request waits are legal until the grant.
- rdata registers hold their value between acks.
- m_ready outside BUSY is ignored.
- Reset mid-transaction: immediate IDLE, m_req and acks drop asynchronously, and no ack is produced for the aborted access.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, BUSY, RESP);
  - grant-owner encoding (OWN_I, OWN_D);
  - default width constants.
- One natural sub-module, arb_pick: the combinational priority/streak decision that takes i_req, d_req and streak, and produces the grant and the next streak value. Its purpose is to let it be verified exhaustively.

Test Plan:
- Fetch only:
  - Stimulus: i_req=1, i_addr=0x0000_0104, memory ready in the first BUSY cycle with m_rdata=0x0050_0093.
  - Required: m_addr=0x0000_0104, m_we=0; i_ack two cycles after the request is seen, with i_rdata=0x0050_0093; accesses repeat every 3 cycles.
- Store with byte enables:
  - Stimulus: d_req, d_addr=0x0000_2003, d_we=4'b1000, d_wdata=0xAB00_0000.
  - Required: m_addr=0x0000_2000, m_we=4'b1000, d_ack a single pulse, i_ack stays 0.
- Contention and starvation:
  - Stimulus: i_req and d_req held high continuously, MAX_DSTREAK=4.
  - Required: grant order D,D,D,D,I,D,D,D,D,I.
- Wait states:
  - Stimulus: memory holds m_ready=0 for 5 BUSY cycles.
  - Required: m_addr, m_we and m_wdata stable throughout; ack follows the 6th cycle; bus_err=0.
- Timeout:
  - Stimulus: TIMEOUT=8, m_ready never asserted.
  - Required: after 8 BUSY cycles, m_req drops; bus_err and d_ack pulse together with d_rdata=0; the next queued I request is then served.
- Reset mid-transaction:
  - Stimulus: assert reset in the 2nd BUSY cycle.
  - Required: m_req=0 and acks=0 immediately; after release, the FSM is in IDLE with streak=0, and a pending request is re-granted fresh.
